// File: rtl/VX_sau_pkg.sv
// Shared types for the SAU operand loader.
// Holds the loader FSM state enum, the row-counter width rule and the element type.
// No ports; imported by vx_sau_operand_loader.
package VX_sau_pkg;

   // Loader FSM states.
   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } sau_state_e;

   // Default geometry of the systolic unit.
   localparam int SAU_MATRIX_SIZE = 3;
   localparam int SAU_DATA_SIZE   = 8;

   // The row counter walks all 2N rows: N rows of A, then N rows of B.
   function automatic int row_cnt_width(input int n);
      return $clog2(2 * n);
   endfunction

   localparam int ROW_CNT_W = row_cnt_width(SAU_MATRIX_SIZE);

   typedef logic [SAU_DATA_SIZE-1:0] sau_elem_t;

endpackage

// File: rtl/vx_sau_operand_loader.sv
// Operand loader: assembles NxN operands A and B from a row stream and launches one SAU job.
// Latency: start pulses the cycle after the last (2N-th) row beat; completion is seen from the 2nd WAIT cycle.
// Backpressure: in_ready is low from ISSUE until the SAU reports completion (and while reset is high).
// Ports: clk/reset (sync, active-high), in_valid/in_ready/in_data row stream,
//        mat_a/mat_b operand arrays [row][col], start pulse, sau_ready completion level,
//        busy job-in-flight flag, done_count completed-job counter (wraps).
module vx_sau_operand_loader
   import VX_sau_pkg::*;
#(
   parameter int MATRIX_SIZE = SAU_MATRIX_SIZE,
   parameter int DATA_SIZE   = SAU_DATA_SIZE
) (
   input  logic                                            clk,
   input  logic                                            reset,
   input  logic                                            in_valid,
   output logic                                            in_ready,
   input  logic [MATRIX_SIZE*DATA_SIZE-1:0]                in_data,
   output logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_SIZE-1:0] mat_a,
   output logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_SIZE-1:0] mat_b,
   output logic                                            start,
   input  logic                                            sau_ready,
   output logic                                            busy,
   output logic [15:0]                                     done_count
);

   localparam int N   = MATRIX_SIZE;
   localparam int RCW = row_cnt_width(N);
   localparam logic [RCW-1:0] LAST_ROW = RCW'(2 * N - 1);

   // Row unpacking: column c of the beat sits at bits [c*DATA_SIZE +: DATA_SIZE].
   logic [N-1:0][DATA_SIZE-1:0] row_w;
   for (genvar c = 0; c < N; c++) begin : g_unpack
      assign row_w[c] = in_data[c*DATA_SIZE +: DATA_SIZE];
   end

   sau_state_e                             state_q, state_d;
   logic [RCW-1:0]                         row_cnt_q, row_cnt_d;
   logic [N-1:0][N-1:0][DATA_SIZE-1:0]     mat_a_q, mat_a_d;
   logic [N-1:0][N-1:0][DATA_SIZE-1:0]     mat_b_q, mat_b_d;
   logic                                   start_q, start_d;
   logic                                   busy_q, busy_d;
   logic                                   first_wait_q, first_wait_d;
   logic [15:0]                            done_count_q, done_count_d;
   logic                                   beat_acc;

   // Ready only depends on the registered state, plus a hard gate during reset.
   assign in_ready = (state_q == LOAD) && !reset;
   assign beat_acc = in_valid && in_ready;

   always_comb begin
      state_d      = state_q;
      row_cnt_d    = row_cnt_q;
      mat_a_d      = mat_a_q;
      mat_b_d      = mat_b_q;
      start_d      = 1'b0;
      busy_d       = busy_q;
      first_wait_d = first_wait_q;
      done_count_d = done_count_q;

      case (state_q)
         LOAD: begin
            busy_d = 1'b0;
            if (beat_acc) begin
               // Compare against each row index instead of indexing with the
               // counter directly, so the counter width never has to match N.
               for (int r = 0; r < N; r++) begin
                  if (row_cnt_q == RCW'(r))     mat_a_d[r] = row_w;
                  if (row_cnt_q == RCW'(r + N)) mat_b_d[r] = row_w;
               end
               if (row_cnt_q == LAST_ROW) begin
                  row_cnt_d = '0;
                  state_d   = ISSUE;
                  start_d   = 1'b1;
                  busy_d    = 1'b1;
               end else begin
                  row_cnt_d = row_cnt_q + RCW'(1);
               end
            end
         end
         ISSUE: begin
            state_d      = WAIT;
            busy_d       = 1'b1;
            first_wait_d = 1'b1;
         end
         WAIT: begin
            // The first WAIT cycle still sees the SAU's ready from the previous
            // job, so it is never treated as completion.
            first_wait_d = 1'b0;
            if (!first_wait_q && sau_ready) begin
               state_d      = LOAD;
               busy_d       = 1'b0;
               done_count_d = done_count_q + 16'd1;
            end
         end
         default: begin
            state_d = LOAD;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= LOAD;
         row_cnt_q    <= '0;
         mat_a_q      <= '0;
         mat_b_q      <= '0;
         start_q      <= 1'b0;
         busy_q       <= 1'b0;
         first_wait_q <= 1'b0;
         done_count_q <= 16'd0;
      end else begin
         state_q      <= state_d;
         row_cnt_q    <= row_cnt_d;
         mat_a_q      <= mat_a_d;
         mat_b_q      <= mat_b_d;
         start_q      <= start_d;
         busy_q       <= busy_d;
         first_wait_q <= first_wait_d;
         done_count_q <= done_count_d;
      end
   end

   assign mat_a      = mat_a_q;
   assign mat_b      = mat_b_q;
   assign start      = start_q;
   assign busy       = busy_q;
   assign done_count = done_count_q;

endmodule

// File: tb/tb_vx_sau_operand_loader.sv
// Bench for vx_sau_operand_loader (N=3, 8-bit elements).
// Directed scenarios followed by a randomized phase, all checked every cycle against a job-level reference.
// Reference tracks rows loaded, job age since the last beat and completed jobs.
module tb_vx_sau_operand_loader;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 in_valid;
   logic                 in_ready;
   logic [23:0]          in_data;
   logic [2:0][2:0][7:0] mat_a;
   logic [2:0][2:0][7:0] mat_b;
   logic                 start;
   logic                 sau_ready;
   logic                 busy;
   logic [15:0]          done_count;

   vx_sau_operand_loader #(.MATRIX_SIZE(3), .DATA_SIZE(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .mat_a      (mat_a),
      .mat_b      (mat_b),
      .start      (start),
      .sau_ready  (sau_ready),
      .busy       (busy),
      .done_count (done_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference: operands as plain arrays, how many rows of the current job
   // have arrived, and the age of the issued job (1 = start cycle).
   logic [7:0]  ma [3][3];
   logic [7:0]  mb [3][3];
   int          m_rows;
   bit          m_job;
   int          m_age;
   logic [15:0] m_cnt;
   int          obs_acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) begin
            ma[r][c] = 8'd0;
            mb[r][c] = 8'd0;
         end
      m_rows = 0;
      m_job  = 1'b0;
      m_age  = 0;
      m_cnt  = 16'd0;
   endtask

   task automatic check_outs();
      chk("start", start, (m_job && m_age == 1));
      chk("busy", busy, m_job);
      chk("done_count", done_count, m_cnt);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) begin
            chk($sformatf("mat_a[%0d][%0d]", r, c), mat_a[r][c], ma[r][c]);
            chk($sformatf("mat_b[%0d][%0d]", r, c), mat_b[r][c], mb[r][c]);
         end
   endtask

   // One clock cycle: drive inputs at the falling edge, check in_ready,
   // advance the reference across the rising edge, check registered outputs.
   task automatic cycle(input bit rst, input bit vld, input logic [23:0] dat, input bit srdy);
      bit exp_rdy;
      reset     = rst;
      in_valid  = vld;
      in_data   = dat;
      sau_ready = srdy;
      #1;
      exp_rdy = !rst && !m_job;
      chk("in_ready", in_ready, exp_rdy);
      if (in_ready === 1'b1 && vld) obs_acc++;
      if (rst) begin
         model_reset();
      end else if (exp_rdy && vld) begin
         for (int c = 0; c < 3; c++) begin
            if (m_rows < 3) ma[m_rows][c]   = dat[c*8 +: 8];
            else            mb[m_rows-3][c] = dat[c*8 +: 8];
         end
         m_rows++;
         if (m_rows == 6) begin
            m_rows = 0;
            m_job  = 1'b1;
            m_age  = 1;
         end
      end else if (m_job) begin
         // Age 1 is the start cycle, age 2 the ignored first wait; from age 3
         // on a high sau_ready finishes the job.
         if (m_age >= 3 && srdy) begin
            m_job = 1'b0;
            m_cnt = m_cnt + 16'd1;
         end else begin
            m_age++;
         end
      end
      @(negedge clk);
      check_outs();
   endtask

   task automatic random_job(input bit srdy);
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 24'($urandom), srdy);
   endtask

   int base;

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = '0; sau_ready = 1'b0;
      obs_acc = 0;
      model_reset();
      @(negedge clk);

      // Reset state.
      cycle(1'b1, 1'b0, 24'h0, 1'b0);
      cycle(1'b1, 1'b1, 24'hABCDEF, 1'b1);
      cycle(1'b0, 1'b0, 24'h0, 1'b0);
      chk("reset_in_ready", in_ready, 1'b1);

      // Basic job: A = 1..9, B = identity, sau_ready held high.
      cycle(1'b0, 1'b1, {8'd3, 8'd2, 8'd1}, 1'b1);
      cycle(1'b0, 1'b1, {8'd6, 8'd5, 8'd4}, 1'b1);
      cycle(1'b0, 1'b1, {8'd9, 8'd8, 8'd7}, 1'b1);
      cycle(1'b0, 1'b1, 24'h000001, 1'b1);
      cycle(1'b0, 1'b1, 24'h000100, 1'b1);
      cycle(1'b0, 1'b1, 24'h010000, 1'b1);
      chk("basic_start_cycle7", start, 1'b1);
      chk("basic_a12", mat_a[1][2], 8'd6);
      chk("basic_b22", mat_b[2][2], 8'd1);
      cycle(1'b0, 1'b0, 24'h0, 1'b1);
      cycle(1'b0, 1'b0, 24'h0, 1'b1);
      cycle(1'b0, 1'b0, 24'h0, 1'b1);
      chk("basic_done_cycle10", done_count, 16'd1);
      chk("basic_ready_cycle10", in_ready, 1'b1);

      // Backpressure and gaps: valid 1,0,0,... and a long SAU stall.
      base = obs_acc;
      for (int i = 0; i < 40; i++) cycle(1'b0, (i % 3 == 0), 24'($urandom), 1'b0);
      chk("bp_beats_accepted", obs_acc - base, 6);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 24'h0, 1'b1);
      chk("bp_done", done_count, 16'd2);

      // Stale ready: sau_ready already high when start pulses.
      random_job(1'b1);
      chk("stale_start", start, 1'b1);
      cycle(1'b0, 1'b0, 24'h0, 1'b1);
      cycle(1'b0, 1'b0, 24'h0, 1'b1);
      chk("stale_first_wait_busy", busy, 1'b1);
      cycle(1'b0, 1'b0, 24'h0, 1'b1);
      chk("stale_second_wait_done", busy, 1'b0);

      // Reset mid-load after 4 beats, then a fresh full job.
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 24'($urandom), 1'b0);
      cycle(1'b1, 1'b0, 24'h0, 1'b0);
      chk("midload_a00", mat_a[0][0], 8'd0);
      chk("midload_cnt", done_count, 16'd0);
      random_job(1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 24'h0, 1'b1);

      // Reset while waiting on the SAU.
      random_job(1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 24'h0, 1'b0);
      cycle(1'b1, 1'b0, 24'h0, 1'b1);
      chk("wait_reset_busy", busy, 1'b0);
      chk("wait_reset_start", start, 1'b0);
      cycle(1'b0, 1'b0, 24'h0, 1'b1);
      chk("wait_reset_no_start", start, 1'b0);
      random_job(1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 24'h0, 1'b1);
      chk("after_wait_reset_done", done_count, 16'd1);

      // Wrap: preload the counter, then complete one job.
      force dut.done_count_q = 16'hFFFF;
      #1;
      release dut.done_count_q;
      m_cnt = 16'hFFFF;
      random_job(1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 24'h0, 1'b1);
      chk("wrap_done", done_count, 16'h0000);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 60) == 0, 1'($urandom_range(0, 1)),
               24'($urandom), $urandom_range(0, 2) != 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
